// File: rtl/block_serial_subtractor.sv
// Multi-cycle subtractor: D = A - B - Bin, computed BLOCK_W bits per cycle, LSB block first,
// with a valid/ready handshake on both sides, unsigned borrow-out and signed overflow flags.
module block_serial_subtractor #(
   parameter int WIDTH   = 32,
   parameter int BLOCK_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] D,
   output logic             Bout,
   output logic             V
);

   localparam int NBLK  = WIDTH / BLOCK_W;
   localparam int CNT_W = (NBLK > 1) ? $clog2(NBLK) : 1;

   generate
      if (WIDTH % BLOCK_W != 0) begin : g_bad_block_w
         $error("block_serial_subtractor: WIDTH must be a multiple of BLOCK_W");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   diff_q, diff_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               borrow_q, borrow_d;
   logic               bout_q, bout_d;
   logic               v_q, v_d;

   logic [31:0]        ofs;
   logic [BLOCK_W-1:0] a_blk, b_blk, blk_diff;
   logic               blk_borrow;
   logic               last_blk;

   // One slice of the ripple: the extra top bit of the widened difference is the block borrow-out.
   always_comb begin
      ofs      = {{(32-CNT_W){1'b0}}, cnt_q} * 32'(BLOCK_W);
      a_blk    = a_q[ofs +: BLOCK_W];
      b_blk    = b_q[ofs +: BLOCK_W];
      {blk_borrow, blk_diff} = {1'b0, a_blk} - {1'b0, b_blk} - {{BLOCK_W{1'b0}}, borrow_q};
      last_blk = (cnt_q == CNT_W'(NBLK - 1));
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      cnt_d    = cnt_q;
      borrow_d = borrow_q;
      bout_d   = bout_q;
      v_d      = v_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               a_d      = A;
               b_d      = B;
               borrow_d = Bin;
               cnt_d    = '0;
               diff_d   = '0;
               bout_d   = 1'b0;
               v_d      = 1'b0;
               state_d  = BUSY;
            end
         end
         BUSY: begin
            diff_d[ofs +: BLOCK_W] = blk_diff;
            borrow_d = blk_borrow;
            cnt_d    = cnt_q + 1'b1;
            if (last_blk) begin
               bout_d  = blk_borrow;
               v_d     = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (blk_diff[BLOCK_W-1] != a_q[WIDTH-1]);
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         cnt_q    <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         cnt_q    <= cnt_d;
         borrow_q <= borrow_d;
         bout_q   <= bout_d;
         v_q      <= v_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign D         = diff_q;
   assign Bout      = bout_q;
   assign V         = v_q;

endmodule
